// File: rtl/four_bit_demux_pkg.sv
// Shared constants, slot state type and counter helper for the 1-to-2 demux.
`default_nettype none

package four_bit_demux_pkg;

  localparam int   DEMUX_WIDTH = 4;
  localparam logic CH_A        = 1'b0;
  localparam logic CH_B        = 1'b1;
  localparam int   COUNT_W     = 8;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_hold_slot.sv
// One-entry holding slot with valid/ready handshake; the consume counter exists
// only when FOUR_BIT_DEMUX_COUNT_EN is defined.
`default_nettype none

module demux_hold_slot
  import four_bit_demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic               ready_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               valid_o,
  output logic               slot_ready_o
`ifdef FOUR_BIT_DEMUX_COUNT_EN
  ,
  output logic [COUNT_W-1:0] count_o
`endif
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             consume;

  assign valid_o      = (state_q == SLOT_FULL);
  assign consume      = valid_o & ready_i;
  assign slot_ready_o = ~valid_o | ready_i;
  assign data_o       = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // A load wins over a same-edge consume, so the slot stays full with new data.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      SLOT_EMPTY: begin
        if (load_i) begin
          state_d = SLOT_FULL;
          data_d  = data_i;
        end
      end
      SLOT_FULL: begin
        if (load_i) begin
          data_d = data_i;
        end else if (ready_i) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

`ifdef FOUR_BIT_DEMUX_COUNT_EN
  logic [COUNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (consume) begin
      count_d = sat_inc(count_q);
    end
  end

  assign count_o = count_q;
`else
  logic unused_consume;
  assign unused_consume = consume;
`endif

endmodule

`default_nettype wire

// File: rtl/four_bit_one_to_two_demux.sv
// Registered 1-to-2 demux: in_select steers each accepted word into slot A or B.
// Optional per-channel consume counters via FOUR_BIT_DEMUX_COUNT_EN.
`default_nettype none

module four_bit_one_to_two_demux
  import four_bit_demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_select,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   a_data,
  output logic               a_valid,
  input  logic               a_ready,
  output logic [WIDTH-1:0]   b_data,
  output logic               b_valid,
  input  logic               b_ready
`ifdef FOUR_BIT_DEMUX_COUNT_EN
  ,
  output logic [COUNT_W-1:0] a_count,
  output logic [COUNT_W-1:0] b_count
`endif
);

  logic a_slot_ready;
  logic b_slot_ready;
  logic accept;
  logic a_load;
  logic b_load;

  // Ready depends only on the selected slot, so a stalled channel never blocks the other.
  assign in_ready = (in_select == CH_B) ? b_slot_ready : a_slot_ready;
  assign accept   = in_valid & in_ready;
  assign a_load   = accept & (in_select == CH_A);
  assign b_load   = accept & (in_select == CH_B);

  demux_hold_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clk          (clk),
    .rst_n        (rst),
    .load_i       (a_load),
    .data_i       (in_data),
    .ready_i      (a_ready),
    .data_o       (a_data),
    .valid_o      (a_valid),
    .slot_ready_o (a_slot_ready)
`ifdef FOUR_BIT_DEMUX_COUNT_EN
    ,
    .count_o      (a_count)
`endif
  );

  demux_hold_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clk          (clk),
    .rst_n        (rst),
    .load_i       (b_load),
    .data_i       (in_data),
    .ready_i      (b_ready),
    .data_o       (b_data),
    .valid_o      (b_valid),
    .slot_ready_o (b_slot_ready)
`ifdef FOUR_BIT_DEMUX_COUNT_EN
    ,
    .count_o      (b_count)
`endif
  );

endmodule

`default_nettype wire

// File: tb/tb_four_bit_one_to_two_demux.sv
// Self-checking bench: directed scenarios plus randomized traffic against an array-based model.
`default_nettype none

module tb_four_bit_one_to_two_demux;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_select;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_valid, b_valid;
  logic         a_ready, b_ready;
`ifdef FOUR_BIT_DEMUX_COUNT_EN
  logic [7:0]   a_count, b_count;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: per-channel fill flag, held word and consume count (index 0 = A, 1 = B).
  bit           m_full [2];
  logic [W-1:0] m_data [2];
  int           m_cnt  [2];

  four_bit_one_to_two_demux #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_select (in_select),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_data    (b_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready)
`ifdef FOUR_BIT_DEMUX_COUNT_EN
    ,
    .a_count   (a_count),
    .b_count   (b_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit rdy_of(input int ch);
    return (ch == 0) ? a_ready : b_ready;
  endfunction

  function automatic bit model_in_ready();
    int s = int'(in_select);
    return !m_full[s] || rdy_of(s);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      m_full[c] = 1'b0;
      m_data[c] = '0;
      m_cnt[c]  = 0;
    end
  endtask

  task automatic model_step();
    bit acc;
    if (!rst) begin
      model_clear();
    end else begin
      acc = in_valid && model_in_ready();
      for (int c = 0; c < 2; c++) begin
        bit cons = m_full[c] && rdy_of(c);
        if (cons && m_cnt[c] < 255) m_cnt[c]++;
        if (acc && int'(in_select) == c) begin
          m_full[c] = 1'b1;
          m_data[c] = in_data;
        end else if (cons) begin
          m_full[c] = 1'b0;
        end
      end
    end
  endtask

  // One clock: the model advances on the edge, then inputs may be changed.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #2;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("a_valid", int'(a_valid), int'(m_full[0]));
      chk("b_valid", int'(b_valid), int'(m_full[1]));
      if (m_full[0] || !rst) chk("a_data", int'(a_data), int'(m_data[0]));
      if (m_full[1] || !rst) chk("b_data", int'(b_data), int'(m_data[1]));
      chk("in_ready", int'(in_ready), int'(model_in_ready()));
`ifdef FOUR_BIT_DEMUX_COUNT_EN
      chk("a_count", int'(a_count), m_cnt[0]);
      chk("b_count", int'(b_count), m_cnt[1]);
`endif
    end
  end

  task automatic set_in(input logic [W-1:0] d, input logic s, input logic v);
    in_data   = d;
    in_select = s;
    in_valid  = v;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_clear();
    #1;
    chk("rst_a_valid", int'(a_valid), 0);
    chk("rst_b_valid", int'(b_valid), 0);
    chk("rst_a_data", int'(a_data), 0);
    chk("rst_b_data", int'(b_data), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    a_ready = 1'b0;
    b_ready = 1'b0;
    set_in('0, 1'b0, 1'b0);
    model_clear();
    #2;
    do_reset();
    cmp_en = 1'b1;

    // Routing
    set_in(4'hA, 1'b0, 1'b1);
    cycle();
    set_in(4'h0, 1'b0, 1'b0);
    #1;
    chk("route_a_valid", int'(a_valid), 1);
    chk("route_a_data", int'(a_data), 'hA);
    chk("route_b_valid", int'(b_valid), 0);
    set_in(4'h5, 1'b1, 1'b1);
    cycle();
    set_in(4'h0, 1'b0, 1'b0);
    #1;
    chk("route_b_valid", int'(b_valid), 1);
    chk("route_b_data", int'(b_data), 'h5);
    chk("route_a_hold", int'(a_data), 'hA);

    // Reset mid-run with both slots full
    do_reset();

    // Backpressure on A, B left free
    b_ready = 1'b1;
    set_in(4'h3, 1'b0, 1'b1);
    cycle();
    set_in(4'h7, 1'b0, 1'b1);
    #1;
    chk("bp_in_ready_a", int'(in_ready), 0);
    in_select = 1'b1;
    #1;
    chk("bp_in_ready_b", int'(in_ready), 1);
    in_select = 1'b0;
    cycle();
    chk("bp_a_held", int'(a_data), 'h3);
    a_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", int'(in_ready), 1);
    cycle();
    set_in(4'h0, 1'b0, 1'b0);
    #1;
    chk("bp_a_data_7", int'(a_data), 'h7);
    chk("bp_a_valid_7", int'(a_valid), 1);
    cycle();
    chk("bp_a_drained", int'(a_valid), 0);

    // Streaming on A
    for (int i = 1; i <= 3; i++) begin
      set_in(W'(i), 1'b0, 1'b1);
      #1;
      chk("stream_in_ready", int'(in_ready), 1);
      cycle();
      chk("stream_a_valid", int'(a_valid), 1);
      chk("stream_a_data", int'(a_data), i);
    end
    set_in(4'h0, 1'b0, 1'b0);
    cycle();
    chk("stream_end_valid", int'(a_valid), 0);

    // Independence: B stalled full, A keeps flowing
    b_ready = 1'b0;
    set_in(4'h9, 1'b1, 1'b1);
    cycle();
    for (int i = 0; i < 6; i++) begin
      set_in(W'(i + 2), (i % 2) == 0, 1'b1);
      #1;
      chk("ind_in_ready", int'(in_ready), (i % 2) == 0 ? 0 : 1);
      cycle();
      chk("ind_b_hold", int'(b_data), 'h9);
      if ((i % 2) == 1) chk("ind_a_flow", int'(a_data), i + 2);
    end
    set_in(4'h0, 1'b0, 1'b0);
    b_ready = 1'b1;
    cycle();
    chk("ind_b_drained", int'(b_valid), 0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      set_in(W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) != 0);
      a_ready = $urandom_range(0, 2) != 0;
      b_ready = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b0;
        model_clear();
      end else begin
        rst = 1'b1;
      end
      cycle();
    end
    rst = 1'b1;
    set_in(4'h0, 1'b0, 1'b0);
    cycle();

`ifdef FOUR_BIT_DEMUX_COUNT_EN
    do_reset();
    a_ready = 1'b1;
    b_ready = 1'b0;
    set_in(4'hC, 1'b0, 1'b1);
    for (int i = 0; i < 305; i++) cycle();
    set_in(4'h0, 1'b0, 1'b0);
    cycle();
    chk("cnt_a_sat", int'(a_count), 255);
    chk("cnt_b_zero", int'(b_count), 0);
`endif

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/four_bit_one_to_two_demux.md
Name: four_bit_one_to_two_demux

Overview:
- Registered 1-to-2 demultiplexer: the distributing counterpart of the datapath's 4-bit 2:1 selector.
- Routes one WIDTH-bit input word, under a select bit, into one of two one-entry holding slots (channel A or channel B).
- Each slot presents its word with a valid/ready handshake.
- Sits in the unpipelined processor's write-back/dispatch path, feeding two consumers from one producer.

Parameters:
- WIDTH, 4, data width of the input word and both output channels.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  word to route.
- in_select  input  1  destination: 0 selects channel A, 1 selects channel B.
- in_valid  input  1  producer offers in_data this cycle.
- in_ready  output  1  block accepts the offered word this cycle.
- a_data  output  WIDTH  channel A held word.
- a_valid  output  1  channel A slot full.
- a_ready  input  1  channel A consumer takes the word this cycle.
- b_data  output  WIDTH  channel B held word.
- b_valid  output  1  channel B slot full.
- b_ready  input  1  channel B consumer takes the word this cycle.

Behaviour:
- Reset (rst low, asynchronous): both slots empty; a_valid=b_valid=0; a_data=b_data=0. Held words are discarded, including on reset mid-transfer.
- Per-slot ready: slot_ready_X = ~X_valid | X_ready.
- in_ready: combinational. Equals slot_ready_A when in_select=0, slot_ready_B when in_select=1. There is no registered path from input to ready beyond the slot state.
- Accept: in_valid & in_ready at a rising edge. The selected slot loads in_data and its valid is 1 next cycle (latency 1). The unselected slot is unaffected.
- Consume: X_valid & X_ready at an edge clears X_valid unless the same edge also accepts into X.
- Simultaneous consume and accept on the same slot: X_valid stays 1 and X_data takes the new word. Throughput is one word per cycle per channel.
- Stability: while X_valid=1 and X_ready=0, X_data is held unchanged.
- in_select may change every cycle. Routing uses the select value sampled at the accepting edge.
- Both slots full, in_valid high, selected consumer not ready: in_ready=0 and the producer holds.
- A stalled channel never blocks the other channel: a word selecting the free channel is accepted.
- in_valid=0: no slot state changes except consumption.
- X_ready while X_valid=0: ignored.
- State per slot is two states, EMPTY and FULL:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on consume without accept.
  - FULL -> FULL on accept+consume.

Optional Feature:
- Macro: FOUR_BIT_DEMUX_COUNT_EN.
- Defined: adds outputs a_count and b_count, 8 bits each.
  - Each counts completed consumes (X_valid & X_ready) on its channel.
  - Saturates at 255. Reset to 0 by rst.
- Undefined: the count ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package four_bit_demux_pkg holds:
  - DEMUX_WIDTH default (4).
  - Channel constants CH_A=1'b0 and CH_B=1'b1.
  - Counter width constant COUNT_W=8.
- Sub-module demux_hold_slot: one-entry buffer with load, data, valid, ready and slot_ready. Instantiated twice; the top only decodes in_select and forms in_ready.

Test Plan:
- Reset: assert rst low mid-run with both slots full -> a_valid=b_valid=0, a_data=b_data=4'h0 immediately (asynchronous), in_ready=1.
- Routing: in_data=4'hA, select=0, valid=1 for one cycle -> next cycle a_valid=1, a_data=4'hA, b_valid=0. Repeat with 4'h5, select=1 -> b_data=4'h5.
- Backpressure: a_ready=0; send 4'h3 then 4'h7 to channel A -> 4'h3 held, in_ready=0 for select=0, in_ready=1 for select=1. Word 4'h7 is accepted one cycle after a_ready rises.
- Streaming: a_ready=1 held; send 4'h1,4'h2,4'h3 on consecutive cycles to A -> a_data shows 1,2,3 on consecutive cycles with a_valid continuously 1 and no stalls.
- Independence: B stalled full (b_ready=0); alternate select 1,0 -> B words stall, A words flow; b_data never changes until b_ready=1.
- FOUR_BIT_DEMUX_COUNT_EN: 300 consumes on channel A -> a_count=255 (saturated), b_count=0.
